enff_bank_wr_arbiter: RTL and testbench

//   Round-robin write arbiter and sequencer for a small register bank built from enable flip-flops.

---
 rtl/enff_bank_wr_arbiter.sv | 157 +++++++++++++++
 tb/tb_enff_bank_wr_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/enff_bank_wr_arbiter.sv
// enff_bank_wr_arbiter
// Round-robin write arbiter for a small enable-flip-flop register bank.
// Each write takes two cycles. In IDLE one requester is granted and its
// address and data are captured. In WRITE a one-hot word enable and an
// ack pulse are driven, and the chosen word loads at the end of that cycle.
// A registered read port returns the old word contents when a read hits the
// word being written in the same cycle.
module enff_bank_wr_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 2,
   parameter int DW   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*AW-1:0]   wr_addr,
   input  logic [NREQ*DW-1:0]   wr_data,
   output logic [NREQ-1:0]      ack,
   output logic [(2**AW)-1:0]   we,
   output logic [DW-1:0]        wdata,
   input  logic [AW-1:0]        rd_addr,
   output logic [DW-1:0]        rd_data
);

   localparam int DEPTH = 2**AW;
   localparam int GW    = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] WRITE = 1'b1;

   // NREQ widened by one bit so the wrapped scan index never overflows
   localparam logic [GW:0]   NREQ_W = (GW+1)'(NREQ);
   localparam logic [GW-1:0] LAST_G = GW'(NREQ-1);

   logic [0:0]       state_q, state_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic [GW-1:0]    ptr_q, ptr_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic [DEPTH-1:0] we_q, we_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   logic [DW-1:0]    rd_data_q, rd_data_d;

   logic             win_found;
   logic [GW-1:0]    win_idx;
   logic [GW:0]      scan;

   logic [DW-1:0]    bank_rd [DEPTH];

   // Rotating priority: scan from ptr upward with wrap, first set req wins
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan      = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan = {1'b0, ptr_q} + (GW+1)'(k);
         if (scan >= NREQ_W) begin
            scan = scan - NREQ_W;
         end
         if (!win_found && req[scan[GW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan[GW-1:0];
         end
      end
   end

   // Sequencer: capture winner in IDLE, then present we/ack for one WRITE cycle
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      ack_d   = '0;
      we_d    = '0;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d = win_idx;
               wdata_d = wr_data[win_idx*DW +: DW];
               ack_d   = NREQ'(1) << win_idx;
               we_d    = DEPTH'(1) << wr_addr[win_idx*AW +: AW];
               state_d = WRITE;
            end
         end
         WRITE: begin
            // The winner drops to lowest priority for the next arbitration
            ptr_d   = (grant_q == LAST_G) ? '0 : grant_q + 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         ack_q   <= '0;
         we_q    <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         ack_q   <= ack_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
      end
   end

   // Storage: one enable flip-flop word per address, loaded by its we bit
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_word
         logic [DW-1:0] word_q, word_d;

         // Load wdata when this word's enable is high, otherwise hold
         always_comb begin
            word_d = we_q[gi] ? wdata_q : word_q;
         end

         // Word register
         always_ff @(posedge clk) begin
            if (rst) begin
               word_q <= '0;
            end else begin
               word_q <= word_d;
            end
         end

         assign bank_rd[gi] = word_q;
      end
   endgenerate

   // Read mux samples pre-write contents, so read-during-write returns old data
   always_comb begin
      rd_data_d = bank_rd[rd_addr];
   end

   // Registered read data
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign ack     = ack_q;
   assign we      = we_q;
   assign wdata   = wdata_q;
   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_enff_bank_wr_arbiter.sv
// Testbench for enff_bank_wr_arbiter.
// The driver models the requesting clients and a transaction-level reference
// (a word array, a priority pointer, and a busy flag for the two-cycle write).
// It pushes the expected write and read responses into queues. A separate
// monitor pops and compares them on the falling edge.
module tb_enff_bank_wr_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 2;
   localparam int DW   = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*AW-1:0] wr_addr;
   logic [NREQ*DW-1:0] wr_data;
   logic [NREQ-1:0]   ack;
   logic [3:0]        we;
   logic [DW-1:0]     wdata;
   logic [AW-1:0]     rd_addr;
   logic [DW-1:0]     rd_data;

   enff_bank_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .ack     (ack),
      .we      (we),
      .wdata   (wdata),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      int         due;
      logic [7:0] val;
   } rd_exp_t;

   typedef struct {
      int         due;
      logic [3:0] ack;
      logic [3:0] we;
      logic [7:0] wdata;
   } wr_exp_t;

   rd_exp_t rq[$];
   wr_exp_t wq[$];

   int checks = 0;
   int errors = 0;
   int n_wr   = 0;

   // client state and stimulus controls
   logic [NREQ-1:0] creq;
   logic [1:0]      caddr [NREQ];
   logic [7:0]      cdata [NREQ];
   logic            rst_v;
   logic [1:0]      rd_sel;

   // reference model state
   logic [7:0] m_bank [4];
   int         m_ptr;
   bit         m_busy;
   int         m_g;
   logic [1:0] m_a;
   logic [7:0] m_d;

   task automatic post(input int i, input logic [1:0] a, input logic [7:0] d);
      creq[i]  = 1'b1;
      caddr[i] = a;
      cdata[i] = d;
   endtask

   // Drive one cycle of stimulus, predict the effect of the coming edge, advance
   task automatic step();
      int g;
      int j;
      rst     = rst_v;
      rd_addr = rd_sel;
      for (int i = 0; i < NREQ; i++) begin
         req[i]               = creq[i];
         wr_addr[i*AW +: AW]  = caddr[i];
         wr_data[i*DW +: DW]  = cdata[i];
      end
      rq.push_back('{due: edge_cnt + 1, val: rst_v ? 8'h00 : m_bank[rd_sel]});
      if (rst_v) begin
         for (int w = 0; w < 4; w++) m_bank[w] = 8'h00;
         m_ptr  = 0;
         m_busy = 1'b0;
      end else if (m_busy) begin
         m_bank[m_a] = m_d;
         m_ptr       = (m_g + 1) % NREQ;
         m_busy      = 1'b0;
      end else begin
         g = -1;
         for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (g < 0 && creq[j]) g = j;
         end
         if (g >= 0) begin
            m_g    = g;
            m_a    = caddr[g];
            m_d    = cdata[g];
            m_busy = 1'b1;
            wq.push_back('{due: edge_cnt + 1, ack: 4'(1 << g),
                           we: 4'(1 << caddr[g]), wdata: cdata[g]});
            creq[g] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_idle(input int maxc);
      int n;
      n = 0;
      while ((creq != '0 || m_busy) && n < maxc) begin
         step();
         n++;
      end
      if (creq != '0 || m_busy) begin
         checks++;
         errors++;
         $display("FAIL run_timeout: pending req=%b busy=%0d after %0d cycles, required idle", creq, m_busy, maxc);
      end
   endtask

   task automatic read_word(input logic [1:0] a);
      rd_sel = a;
      step();
   endtask

   // Monitor: compare DUT outputs with queued expectations
   initial begin
      forever begin
         @(negedge clk);
         while (rq.size() > 0 && rq[0].due < edge_cnt) begin
            checks++;
            errors++;
            $display("FAIL rd_missed: read due at edge %0d never checked", rq[0].due);
            void'(rq.pop_front());
         end
         if (rq.size() > 0 && rq[0].due == edge_cnt) begin
            checks++;
            if (rd_data !== rq[0].val) begin
               errors++;
               $display("FAIL rd_data: edge %0d got %h required %h", edge_cnt, rd_data, rq[0].val);
            end
            void'(rq.pop_front());
         end
         if (wq.size() > 0 && wq[0].due == edge_cnt) begin
            checks++;
            n_wr++;
            if (ack !== wq[0].ack || we !== wq[0].we || wdata !== wq[0].wdata) begin
               errors++;
               $display("FAIL write: edge %0d got ack=%b we=%b wdata=%h required ack=%b we=%b wdata=%h",
                        edge_cnt, ack, we, wdata, wq[0].ack, wq[0].we, wq[0].wdata);
            end else begin
               $display("write %0d: edge %0d ack=%b we=%b wdata=%h ok", n_wr, edge_cnt, ack, we, wdata);
            end
            void'(wq.pop_front());
         end else begin
            checks++;
            if (ack !== '0 || we !== '0) begin
               errors++;
               $display("FAIL idle_out: edge %0d got ack=%b we=%b required 0", edge_cnt, ack, we);
            end
         end
      end
   end

   // Stimulus
   initial begin
      creq   = '0;
      rst_v  = 1'b1;
      rd_sel = 2'd0;
      m_ptr  = 0;
      m_busy = 1'b0;
      m_g    = 0;
      m_a    = '0;
      m_d    = '0;
      for (int i = 0; i < NREQ; i++) begin
         caddr[i] = 2'(i);
         cdata[i] = 8'h00;
      end
      for (int w = 0; w < 4; w++) m_bank[w] = 8'h00;

      // reset held two cycles with everyone requesting
      creq = 4'b1111;
      step();
      step();
      creq  = '0;
      rst_v = 1'b0;
      for (int w = 0; w < 4; w++) read_word(2'(w));

      // single write
      post(1, 2'd2, 8'hA5);
      run_until_idle(10);
      read_word(2'd2);
      read_word(2'd2);

      // all request at once
      for (int i = 0; i < NREQ; i++) post(i, 2'(i), 8'h10 + 8'(i));
      run_until_idle(20);
      for (int w = 0; w < 4; w++) read_word(2'(w));
      read_word(2'd0);

      // rotation: grant 2, then 0 and 2 requesting gives 0 first
      post(2, 2'd1, 8'h5A);
      run_until_idle(10);
      post(0, 2'd0, 8'h33);
      post(2, 2'd2, 8'h44);
      run_until_idle(10);

      // same-word conflict after reset (ptr = 0)
      rst_v = 1'b1;
      step();
      rst_v  = 1'b0;
      rd_sel = 2'd3;
      post(0, 2'd3, 8'h11);
      post(1, 2'd3, 8'h22);
      run_until_idle(10);
      read_word(2'd3);
      read_word(2'd3);

      // reset during the WRITE cycle
      post(3, 2'd1, 8'hFF);
      rd_sel = 2'd1;
      step();
      rst_v = 1'b1;
      step();
      rst_v = 1'b0;
      read_word(2'd1);
      read_word(2'd1);
      post(1, 2'd0, 8'h77);
      post(3, 2'd1, 8'h88);
      run_until_idle(10);
      read_word(2'd1);
      read_word(2'd0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!creq[i]) begin
               if ($urandom_range(0, 99) < 30) post(i, 2'($urandom_range(0, 3)), 8'($urandom));
            end else if ($urandom_range(0, 99) < 2) begin
               creq[i] = 1'b0;
            end
         end
         rst_v  = ($urandom_range(0, 199) == 0);
         rd_sel = 2'($urandom_range(0, 3));
         step();
      end
      rst_v = 1'b0;
      run_until_idle(40);
      for (int w = 0; w < 4; w++) read_word(2'(w));

      // let the monitor drain
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (rq.size() != 0 || wq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d reads and %0d writes left, required 0", rq.size(), wq.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
